register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 49 ++++
 tb/tb_register_file.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// rtl/register_file.sv - 2**ADDR_W x DATA_W register file, two async read ports, top index hardwired to zero
// Optional write-through forwarding on the read ports when REGFILE_WRITE_BYPASS_EN is defined.
module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] w_add_i,
  input  logic [DATA_W-1:0] w_dat_i,
  input  logic              write_en_i,
  input  logic [ADDR_W-1:0] a_add_sel,
  input  logic [ADDR_W-1:0] b_add_sel,
  output logic [DATA_W-1:0] r_port_a_o,
  output logic [DATA_W-1:0] r_port_b_o
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = '1;

  // Only the writable registers are stored; the top index never gets a flop.
  logic [DATA_W-1:0] store [NREG-1];
  logic              wr_ok;

  assign wr_ok = write_en_i && (w_add_i != ZERO_IDX);

  for (genvar i = 0; i < NREG - 1; i++) begin : g_reg
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        store[i] <= '0;
      end else if (wr_ok && (w_add_i == ADDR_W'(i))) begin
        store[i] <= w_dat_i;
      end
    end
  end

  always_comb begin
    r_port_a_o = '0;
    r_port_b_o = '0;
    if (a_add_sel != ZERO_IDX) r_port_a_o = store[a_add_sel];
    if (b_add_sel != ZERO_IDX) r_port_b_o = store[b_add_sel];
`ifdef REGFILE_WRITE_BYPASS_EN
    // Forwarding is suppressed during reset so the ports still read zero.
    if (rst_ni && wr_ok && (a_add_sel == w_add_i)) r_port_a_o = w_dat_i;
    if (rst_ni && wr_ok && (b_add_sel == w_add_i)) r_port_b_o = w_dat_i;
`endif
  end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - self-checking bench for register_file (either REGFILE_WRITE_BYPASS_EN setting)
module tb_register_file;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [4:0]  w_add_i;
  logic [31:0] w_dat_i;
  logic        write_en_i;
  logic [4:0]  a_add_sel;
  logic [4:0]  b_add_sel;
  logic [31:0] r_port_a_o;
  logic [31:0] r_port_b_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          chk_en  = 0;
  logic [31:0] model [32];

  register_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .w_add_i    (w_add_i),
    .w_dat_i    (w_dat_i),
    .write_en_i (write_en_i),
    .a_add_sel  (a_add_sel),
    .b_add_sel  (b_add_sel),
    .r_port_a_o (r_port_a_o),
    .r_port_b_o (r_port_b_o)
  );

  always #5 clk_i = ~clk_i;

  // Architectural state: cleared by reset, one write per rising edge, index 31 ignored.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (write_en_i === 1'b1 && w_add_i != 5'd31) begin
      model[w_add_i] = w_dat_i;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd31) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (rst_ni && write_en_i && w_add_i != 5'd31 && a == w_add_i) return w_dat_i;
`endif
    return model[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (chk_en) begin
      check("model_port_a", r_port_a_o, exp_rd(a_add_sel));
      check("model_port_b", r_port_b_o, exp_rd(b_add_sel));
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    w_add_i = a; w_dat_i = d; write_en_i = 1'b1;
    step();
    write_en_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; write_en_i = 1'b0; w_add_i = 5'd0; w_dat_i = 32'h0;
    a_add_sel = 5'd0; b_add_sel = 5'd0;
    #12;
    chk_en = 1;

    // Writes during reset are ignored and ports read zero.
    a_add_sel = 5'd5; b_add_sel = 5'd5;
    w_add_i = 5'd5; w_dat_i = 32'h5555_5555; write_en_i = 1'b1;
    #1 check("reset_read_a", r_port_a_o, 32'h0);
    step();
    check("reset_write_ignored", r_port_b_o, 32'h0);
    write_en_i = 1'b0;
    #2 rst_ni = 1'b1;

    for (int i = 0; i < 32; i++) begin
      a_add_sel = 5'(i); b_add_sel = 5'(31 - i);
      #1;
      check("post_reset_a", r_port_a_o, 32'h0);
      check("post_reset_b", r_port_b_o, 32'h0);
    end

    wr(5'd5, 32'hDEAD_BEEF);
    wr(5'd6, 32'h1234_5678);
    a_add_sel = 5'd5; b_add_sel = 5'd6;
    #1 check("r5_on_a", r_port_a_o, 32'hDEAD_BEEF);
    check("r6_on_b", r_port_b_o, 32'h1234_5678);
    b_add_sel = 5'd5;
    #1 check("same_reg_a", r_port_a_o, 32'hDEAD_BEEF);
    check("same_reg_b", r_port_b_o, 32'hDEAD_BEEF);

    wr(5'd30, 32'h3030_3030);
    a_add_sel = 5'd31; b_add_sel = 5'd30;
    wr(5'd31, 32'hFFFF_FFFF);
    check("r31_zero", r_port_a_o, 32'h0);
    check("r30_kept", r_port_b_o, 32'h3030_3030);

    wr(5'd3, 32'h0000_0033);
    w_add_i = 5'd3; w_dat_i = 32'hAAAA_5555; write_en_i = 1'b0;
    a_add_sel = 5'd3;
    step();
    check("we0_r3_kept", r_port_a_o, 32'h0000_0033);

    wr(5'd9, 32'h0000_0099);
    w_add_i = 5'd9; w_dat_i = 32'hCAFE_0001; write_en_i = 1'b1; a_add_sel = 5'd9;
    #2;
`ifdef REGFILE_WRITE_BYPASS_EN
    check("r9_before_edge", r_port_a_o, 32'hCAFE_0001);
`else
    check("r9_before_edge", r_port_a_o, 32'h0000_0099);
`endif
    step();
    write_en_i = 1'b0;
    check("r9_after_edge", r_port_a_o, 32'hCAFE_0001);

    for (int i = 0; i < 31; i++) begin
      a_add_sel = 5'(i); b_add_sel = 5'(i + 1);
      wr(5'(i), (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000);
    end
    a_add_sel = 5'd17;
    #1 check("sweep_r17", r_port_a_o, 32'h1111_1111 ^ 32'h5A5A_0000);

    wr(5'd7, 32'h0000_0001);
    a_add_sel = 5'd7; b_add_sel = 5'd9;
    #1 check("r7_set", r_port_a_o, 32'h0000_0001);
    #1 rst_ni = 1'b0;
    #1 check("async_reset_r7", r_port_a_o, 32'h0);
    check("async_reset_r9", r_port_b_o, 32'h0);

    // Reset released just before an edge that carries a write: the write lands.
    w_add_i = 5'd4; w_dat_i = 32'h0000_0044; write_en_i = 1'b1; a_add_sel = 5'd4;
    @(negedge clk_i);
    #3 rst_ni = 1'b1;
    step();
    write_en_i = 1'b0;
    check("write_at_release", r_port_a_o, 32'h0000_0044);

    // Reset mid-cycle with a pending write: nothing is stored.
    w_add_i = 5'd8; w_dat_i = 32'h0000_0088; write_en_i = 1'b1; a_add_sel = 5'd8;
    #2 rst_ni = 1'b0;
    step();
    check("reset_beats_write", r_port_a_o, 32'h0);
    write_en_i = 1'b0;
    #2 rst_ni = 1'b1;
    step();
    step();

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
